// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared widths and FSM encoding for the sequential divider
package seq_div_pkg;
    localparam int NW_DEF = 36;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int nw);
        return $clog2(nw + 1);
    endfunction
endpackage

// File: rtl/seq_div_if.sv
// seq_div_if: start/busy/done handshake and operand/result bus of seq_div
interface seq_div_if import seq_div_pkg::*; #(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) ();
    logic          start;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          dbz;
    modport master (output start, dividend, divisor, input quotient, remainder, busy, done, dbz);
    modport slave  (input start, dividend, divisor, output quotient, remainder, busy, done, dbz);
endinterface

// File: rtl/seq_div.sv
// seq_div: restoring divider, one quotient bit per clock, start/busy/done handshake
module seq_div import seq_div_pkg::*; #(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic   clk,
    input  logic   reset,
    seq_div_if.slave bus
);
    localparam int CW = cnt_w(NW);
    state_t        r_state, w_next;
    logic [NW-1:0] r_q, r_quo, w_q_nxt;
    logic [DW:0]   r_p, w_p_nxt;
    logic [DW-1:0] r_d, r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_dbz, w_acc, w_last, w_neg;
    logic [DW+1:0] w_sh, w_trial;
    assign w_acc   = bus.start && (r_state != RUN);
    assign w_last  = (r_state == RUN) && (r_cnt == CW'(NW - 1));
    // partial stays below the divisor, so the top bit of w_sh is always zero
    assign w_sh    = {r_p, r_q[NW-1]};
    assign w_trial = w_sh - {2'b0, r_d};
    assign w_neg   = w_trial[DW+1];
    assign w_p_nxt = w_neg ? w_sh[DW:0] : w_trial[DW:0];
    assign w_q_nxt = {r_q[NW-2:0], ~w_neg};
    always_comb begin
        w_next = r_state;
        if (w_acc)
            w_next = (bus.divisor == '0) ? DONE : RUN;
        else if (r_state == RUN)
            w_next = w_last ? DONE : RUN;
        else if (r_state == DONE)
            w_next = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            r_p   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
        end else if (w_acc) begin
            r_q   <= bus.dividend;
            r_d   <= bus.divisor;
            r_p   <= '0;
            r_cnt <= '0;
            r_dbz <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
                r_quo <= '1;
                r_rem <= '0;
            end
        end else if (r_state == RUN) begin
            r_q   <= w_q_nxt;
            r_p   <= w_p_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_quo <= w_q_nxt;
                r_rem <= w_p_nxt[DW-1:0];
            end
        end
    end
    assign bus.quotient  = r_quo;
    assign bus.remainder = r_rem;
    assign bus.dbz       = r_dbz;
    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
endmodule
